// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive line buffer.
//   ASCII_LF / ASCII_CR : line terminator and carriage return codes
//   line_state_e        : receive-side line FSM (ACCEPT, DISCARD)
package uart_pkg;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } line_state_e;

endpackage

// File: rtl/line_fifo_mem.sv
// DEPTH x DATA_W simple dual-port RAM with a registered read port.
// Written to infer block RAM, so the array and read register have no reset.
// Ports:
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata is updated the following cycle
//   rdata        : registered read data, holds its value when re=0
module line_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/uart_rx_line_fifo.sv
// Line-oriented receive FIFO behind the UART receiver. Bytes are written
// speculatively and only become readable once their LF-terminated line is
// complete. A line that does not fit is dropped whole and flagged.
//
// Optional feature (define UART_LINE_CR_STRIP_EN): carriage returns (8'h0D)
// are discarded on input and never occupy the FIFO.
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   in_byte      : byte from the UART receiver, qualified by in_valid
//   in_valid     : one-cycle byte strobe
//   rd_en        : pop request, ignored while rd_avail=0
//   rd_data      : popped byte, one cycle after an accepted rd_en
//   rd_valid     : one-cycle strobe qualifying rd_data
//   rd_avail     : at least one committed byte unread
//   line_count   : complete lines stored and not yet fully popped
//   overflow     : sticky flag, a line was dropped since the last clear
//   drop_count   : saturating dropped-line counter
//   clr_ovf      : clears overflow and drop_count (a coincident drop wins)
module uart_rx_line_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  rd_avail,
  output logic [ADDR_W:0]       line_count,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count,
  input  logic                  clr_ovf
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       commit_ptr_q, commit_ptr_d;
  logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
  line_state_e           state_q, state_d;
  logic [ADDR_W:0]       line_count_q, line_count_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
  logic                  vld_p1;
  logic                  rd_seen_q;

  logic                  full;
  logic                  is_lf;
  logic                  is_cr;
  logic                  mem_we;
  logic                  rd_accept;
  logic                  line_inc;
  logic                  line_dec;
  logic                  drop;
  logic [7:0]            mem_rdata;

  assign full  = (wr_ptr_q - rd_ptr_q) == DEPTH_L;
  assign is_lf = in_byte == ASCII_LF;
`ifdef UART_LINE_CR_STRIP_EN
  assign is_cr = in_byte == ASCII_CR;
`else
  assign is_cr = 1'b0;
`endif

  // ---- Write side: speculative write, commit on LF, whole-line drop ----
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we       = 1'b0;
    line_inc     = 1'b0;
    drop         = 1'b0;
    if (in_valid && !is_cr) begin
      case (state_q)
        ACCEPT: begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (is_lf) begin
              commit_ptr_d = wr_ptr_q + 1'b1;
              line_inc     = 1'b1;
            end
          end else begin
            // Discard the partial line; an LF here means the line ended
            // exactly at the drop point, so nothing remains to skip.
            wr_ptr_d = commit_ptr_q;
            drop     = 1'b1;
            if (!is_lf) begin
              state_d = DISCARD;
            end
          end
        end
        DISCARD: begin
          if (is_lf) begin
            state_d = ACCEPT;
          end
        end
        default: state_d = ACCEPT;
      endcase
    end
  end

  // ---- Read side: pop request, RAM read registered as stage p1 ----
  assign rd_avail  = rd_ptr_q != commit_ptr_q;
  assign rd_accept = rd_en && rd_avail;
  assign rd_ptr_d  = rd_ptr_q + {{ADDR_W{1'b0}}, rd_accept};

  line_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (in_byte),
    .re    (rd_accept),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  // ---- Stage p1: popped byte visible, line bookkeeping ----
  // A line leaves the count when its LF appears on the RAM output.
  assign line_dec = vld_p1 && (mem_rdata == ASCII_LF);

  always_comb begin
    line_count_d = line_count_q;
    case ({line_inc, line_dec})
      2'b10:   line_count_d = line_count_q + 1'b1;
      2'b01:   line_count_d = line_count_q - 1'b1;
      default: line_count_d = line_count_q;
    endcase
  end

  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      overflow_d   = 1'b1;
      drop_count_d = clr_ovf ? {{(DROP_CNT_W-1){1'b0}}, 1'b1} : sat_inc(drop_count_q);
    end else if (clr_ovf) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      state_q      <= ACCEPT;
      line_count_q <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      vld_p1       <= 1'b0;
      rd_seen_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      line_count_q <= line_count_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      vld_p1       <= rd_accept;
      rd_seen_q    <= rd_seen_q | rd_accept;
    end
  end

  // The RAM read register has no reset; rd_seen_q masks it to zero from
  // reset until the first pop has loaded it.
  assign rd_data    = rd_seen_q ? mem_rdata : 8'h00;
  assign rd_valid   = vld_p1;
  assign line_count = line_count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule
